// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, credit-limited imem request issue, response FIFO and redirect/drop handling.
module instr_fetch_unit #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int BUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pcplus4,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int SW = CW + 2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word_q [BUF_DEPTH];
    logic [XLEN-1:0] tag_q [BUF_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count_buf, count_live, count_drop;
    logic [SW-1:0] budget;
    logic [XLEN-1:0] rsp_tag;
    logic acc, push, pop, drop_hit;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction
    always_comb begin
        budget = SW'(count_buf) + SW'(count_live) + SW'(count_drop);
        imem_req_valid = !reset && (budget < SW'(BUF_DEPTH));
        acc = imem_req_valid && imem_req_ready;
        drop_hit = imem_rsp_valid && (count_drop != '0);
        push = imem_rsp_valid && (count_drop == '0) && !redirect_valid;
        instr_valid = !reset && (count_buf != '0) && !redirect_valid;
        pop = instr_valid && instr_ready;
        // live requests are consecutive words ending just below pc, so the oldest one's address is recoverable
        rsp_tag = pc - (XLEN'(count_live) << 2);
    end
    assign imem_addr = pc;
    assign instr = word_q[rd_ptr];
    assign instr_pc = tag_q[rd_ptr];
    assign instr_pcplus4 = instr_pc + XLEN'(4);
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
            count_buf <= '0;
            count_live <= '0;
            count_drop <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ~XLEN'(3);
            count_drop <= count_drop + count_live + CW'(acc) - CW'(imem_rsp_valid);
            count_live <= '0;
            count_buf <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (acc) pc <= pc + XLEN'(4);
            count_drop <= count_drop - CW'(drop_hit);
            count_live <= count_live + CW'(acc) - CW'(push);
            count_buf <= count_buf + CW'(push) - CW'(pop);
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr] <= imem_rsp_data;
            tag_q[wr_ptr] <= rsp_tag;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch streaming, backpressure, redirects and pc wrap.
module tb_instr_fetch_unit;
    logic clk, reset;
    logic imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data;
    logic instr_valid, instr_ready, redirect_valid;
    logic [31:0] instr, instr_pc, instr_pcplus4, redirect_pc;
    logic w_req_valid, w_rsp_valid, w_instr_valid;
    logic [31:0] w_addr, w_rsp_data, w_instr, w_pc, w_pcplus4;
    typedef struct {
        logic [31:0] a;
        int due;
    } req_t;
    req_t q[$];
    int cyc, lat, checks, failures, ndeliv, nacc;
    logic [31:0] exp_pc, w_last;
    logic w_acc;
    instr_fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_pcplus4(instr_pcplus4),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );
    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_addr(w_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .instr_valid(w_instr_valid), .instr_ready(1'b1), .instr(w_instr),
        .instr_pc(w_pc), .instr_pcplus4(w_pcplus4),
        .redirect_valid(1'b0), .redirect_pc(32'h0)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk)
        if (!reset && imem_rsp_valid)
            assert (dut.count_live != 0 || dut.count_drop != 0)
            else $error("illegal response with nothing outstanding");
    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick();
        if (reset) q.delete();
        else begin
            if (imem_rsp_valid) void'(q.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                q.push_back('{imem_addr, cyc + lat});
                nacc++;
            end
            if (instr_valid && instr_ready) begin
                chk("deliv_pc", instr_pc, exp_pc);
                chk("deliv_word", instr, f(exp_pc));
                chk("deliv_pc4", instr_pcplus4, exp_pc + 32'd4);
                exp_pc += 32'd4;
                ndeliv++;
            end
        end
        w_acc = w_req_valid;
        w_last = w_addr;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        imem_rsp_valid = (q.size() > 0) ? (q[0].due <= cyc) : 1'b0;
        imem_rsp_data = imem_rsp_valid ? f(q[0].a) : 32'h0;
        w_rsp_valid = w_acc;
        w_rsp_data = f(w_last);
        #1;
    endtask
    initial begin
        reset = 1; imem_req_ready = 1; instr_ready = 1; redirect_valid = 0; redirect_pc = 0;
        imem_rsp_valid = 0; imem_rsp_data = 0; w_rsp_valid = 0; w_rsp_data = 0;
        cyc = 0; lat = 1; checks = 0; failures = 0; ndeliv = 0; nacc = 0; exp_pc = 0;
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_instr_valid", instr_valid, 0);
            tick();
        end
        reset = 0; #1;
        chk("req_after_rst", imem_req_valid, 1);
        chk("addr_after_rst", imem_addr, 32'h0);
        chk("w_addr0", w_addr, 32'hFFFF_FFF8);
        tick();
        chk("w_addr1", w_addr, 32'hFFFF_FFFC);
        chk("first_latency", instr_valid, 0);
        tick();
        chk("w_addr2", w_addr, 32'h0);
        chk("first_valid", instr_valid, 1);
        chk("w_pc0", w_pc, 32'hFFFF_FFF8);
        chk("w_pc4_0", w_pcplus4, 32'hFFFF_FFFC);
        tick();
        chk("w_pc1", w_pc, 32'hFFFF_FFFC);
        chk("w_pc4_wrap", w_pcplus4, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("stream_nogap", instr_valid, 1);
            tick();
        end
        chk("stream_count", 32'(ndeliv), 32'd10);
        reset = 1; instr_ready = 0; #1;
        tick();
        reset = 0; exp_pc = 0; nacc = 0; ndeliv = 0; #1;
        for (int i = 0; i < 10; i++) begin
            if (i >= 5) begin
                chk("stall_valid", instr_valid, 1);
                chk("stall_pc", instr_pc, 32'h0);
                chk("stall_word", instr, f(32'h0));
            end
            tick();
        end
        chk("stall_reqs", 32'(nacc), 32'd4);
        chk("stall_issue_stop", imem_req_valid, 0);
        instr_ready = 1; #1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_nogap", instr_valid, 1);
            tick();
        end
        chk("drain_count", 32'(ndeliv), 32'd4);
        reset = 1; lat = 3; #1;
        tick();
        reset = 0; exp_pc = 32'h100; ndeliv = 0; #1;
        tick();
        tick();
        imem_req_ready = 0; redirect_valid = 1; redirect_pc = 32'h103; #1;
        tick();
        imem_req_ready = 1; redirect_valid = 0; #1;
        chk("redir_req_valid", imem_req_valid, 1);
        chk("redir_addr", imem_addr, 32'h100);
        for (int i = 0; i < 6; i++) tick();
        chk("redir_deliv", 32'(ndeliv), 32'd2);
        reset = 1; lat = 1; #1;
        tick();
        reset = 0; exp_pc = 0; ndeliv = 0; #1;
        tick();
        tick();
        redirect_valid = 1; redirect_pc = 32'h200; exp_pc = 32'h200; #1;
        chk("redir_gate", instr_valid, 0);
        chk("redir_acc", imem_req_valid, 1);
        tick();
        redirect_valid = 0; #1;
        chk("coin_addr", imem_addr, 32'h200);
        chk("coin_drop1", 32'(dut.count_drop), 32'd1);
        tick();
        chk("coin_drop0", 32'(dut.count_drop), 32'd0);
        tick();
        chk("coin_valid", instr_valid, 1);
        chk("coin_pc", instr_pc, 32'h200);
        tick();
        redirect_valid = 1; redirect_pc = 32'h300; exp_pc = 32'h400; #1;
        tick();
        redirect_pc = 32'h402; #1;
        tick();
        redirect_valid = 0; #1;
        chk("b2b_addr", imem_addr, 32'h400);
        for (int i = 0; i < 6; i++) tick();
        chk("b2b_deliv", 32'(ndeliv), 32'd5);
        chk("b2b_drop0", 32'(dut.count_drop), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
